ami_burst_gen: RTL and testbench

AMI_BURST_GEN -- requirements
Module: ami_burst_gen

---
 rtl/ami_burst_gen.sv | 209 ++++++++++++++++++++
 tb/tb_ami_burst_gen.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ami_burst_gen.sv
// ami_burst_gen: splits per-channel DMA commands into AXI INCR bursts with round-robin arbitration.
// Optional macro AMI_BG_4K_SPLIT_EN keeps every burst inside a single 4 KB page.
module ami_burst_gen #(
  parameter int AXI_DW = 128,
  parameter int AXI_AW = 32,
  parameter int AXI_IW = 8,
  parameter int AXI_LW = 8,
  parameter int NCH    = 4,
  parameter int BL     = 16,
  parameter int OD     = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [NCH-1:0]    cfg_dma_valid,
  output logic [NCH-1:0]    cfg_dma_ready,
  input  logic [NCH*32-1:0] cfg_dma_sa,
  input  logic [NCH*32-1:0] cfg_dma_len,
  input  logic [NCH-1:0]    dma_irq_w1c,
  output logic [NCH-1:0]    dma_irq,
  output logic [NCH*4-1:0]  dma_err,
  output logic [AXI_IW-1:0] axid,
  output logic [AXI_AW-1:0] axaddr,
  output logic [AXI_LW-1:0] axlen,
  output logic [2:0]        axsize,
  output logic [1:0]        axburst,
  output logic              axvalid,
  input  logic              axready,
  input  logic [AXI_IW-1:0] usr_bid,
  input  logic [1:0]        usr_bresp,
  input  logic              usr_bvalid,
  output logic              usr_bready
);

  localparam int L  = $clog2(AXI_DW / 8);
  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int OW = $clog2(OD + 1);
  localparam int BW = $clog2(BL) + 1;
  localparam logic [31:0] LMASK = (32'd1 << L) - 32'd1;

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, ISSUE = 2'd2} state_t;

  state_t            state_r, state_nxt_s;
  logic              rdy_en_r;
  logic [NCH-1:0]    busy_r, irq_r;
  logic [31:0]       addr_r [NCH];
  logic [31:0]       rem_r  [NCH];
  logic [OW-1:0]     ost_r  [NCH];
  logic [3:0]        err_r  [NCH];
  logic [3:0]        err_nxt_s [NCH];
  logic [OW-1:0]     gost_r;
  logic [CW-1:0]     rr_r, sel_r, grant_s;
  logic              grant_vld_s;
  logic [BW-1:0]     beats_r, beats_s;
  logic [31:0]       rem_beats_s, lim_s, step_s;
`ifdef AMI_BG_4K_SPLIT_EN
  logic [31:0]       page_beats_s;
`endif
  logic              axvalid_r;
  logic [AXI_IW-1:0] axid_r;
  logic [AXI_AW-1:0] axaddr_r;
  logic [AXI_LW-1:0] axlen_r;
  logic              hs_s, rsp_ok_s;
  logic [NCH-1:0]    acc_s, sa_bad_s, len_bad_s, inc_s, dec_s, done_s, irq_set_s;

  // rdy_en_r keeps ready low throughout reset and the edge that releases it
  assign cfg_dma_ready = {NCH{rdy_en_r}} & ~busy_r & ~irq_r;
  assign dma_irq       = irq_r;
  assign axvalid       = axvalid_r;
  assign axid          = axid_r;
  assign axaddr        = axaddr_r;
  assign axlen         = axlen_r;
  assign axsize        = 3'(L);
  assign axburst       = 2'b01;
  assign usr_bready    = 1'b1;
  assign hs_s          = axvalid_r & axready;
  assign rsp_ok_s      = usr_bvalid && (32'(usr_bid) < 32'(NCH));
  assign step_s        = 32'(beats_r) << L;

  for (genvar g = 0; g < NCH; g++) begin : g_err
    assign dma_err[g*4 +: 4] = err_r[g];
  end

  // Round-robin pick: lowest offset from rr_r wins, so scan offsets downward
  always_comb begin
    grant_vld_s = 1'b0;
    grant_s     = '0;
    for (int k = NCH - 1; k >= 0; k--) begin
      if (busy_r[(int'(rr_r) + k) % NCH] && (rem_r[(int'(rr_r) + k) % NCH] != 32'd0)) begin
        grant_vld_s = 1'b1;
        grant_s     = CW'((int'(rr_r) + k) % NCH);
      end else begin
        grant_vld_s = grant_vld_s;
      end
    end
  end

  // Burst length for the selected channel
  always_comb begin
    rem_beats_s = rem_r[sel_r] >> L;
    lim_s       = (rem_beats_s < 32'(BL)) ? rem_beats_s : 32'(BL);
`ifdef AMI_BG_4K_SPLIT_EN
    page_beats_s = (32'd4096 - {20'd0, addr_r[sel_r][11:0]}) >> L;
    lim_s        = (page_beats_s < lim_s) ? page_beats_s : lim_s;
`endif
    beats_s = BW'(lim_s);
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next state; outstanding limit is checked only when picking a channel
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE:    state_nxt_s = (grant_vld_s && (32'(gost_r) < 32'(OD))) ? CALC : IDLE;
      CALC:    state_nxt_s = ISSUE;
      ISSUE:   state_nxt_s = hs_s ? IDLE : ISSUE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Grant capture and registered burst fields
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rr_r      <= '0;
      sel_r     <= '0;
      beats_r   <= '0;
      axvalid_r <= 1'b0;
      axid_r    <= '0;
      axaddr_r  <= '0;
      axlen_r   <= '0;
    end else begin
      if ((state_r == IDLE) && (state_nxt_s == CALC)) begin
        sel_r <= grant_s;
        rr_r  <= (32'(grant_s) == 32'(NCH - 1)) ? '0 : grant_s + CW'(1);
      end
      if (state_r == CALC) begin
        beats_r   <= beats_s;
        axvalid_r <= 1'b1;
        axid_r    <= AXI_IW'(sel_r);
        axaddr_r  <= addr_r[sel_r][AXI_AW-1:0];
        axlen_r   <= AXI_LW'(beats_s - BW'(1));
      end else if (hs_s) begin
        axvalid_r <= 1'b0;
      end
    end
  end

  // Per-channel command checks, counter steps and irq/err next values
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      sa_bad_s[i]  = (cfg_dma_sa[i*32 +: 32] & LMASK) != 32'd0;
      len_bad_s[i] = (cfg_dma_len[i*32 +: 32] == 32'd0) || ((cfg_dma_len[i*32 +: 32] & LMASK) != 32'd0);
      acc_s[i]     = cfg_dma_valid[i] & cfg_dma_ready[i];
      inc_s[i]     = hs_s && (sel_r == CW'(i));
      dec_s[i]     = rsp_ok_s && (usr_bid == AXI_IW'(i)) && (ost_r[i] != '0);
      done_s[i]    = busy_r[i] && (rem_r[i] == 32'd0) && (ost_r[i] == '0);
      irq_set_s[i] = done_s[i] | (acc_s[i] & (sa_bad_s[i] | len_bad_s[i]));
      err_nxt_s[i] = (dma_irq_w1c[i] && !irq_set_s[i]) ? 4'd0 : err_r[i];
      err_nxt_s[i] = acc_s[i] ? {2'b00, len_bad_s[i], sa_bad_s[i]} : err_nxt_s[i];
      if (rsp_ok_s && (usr_bid == AXI_IW'(i))) begin
        err_nxt_s[i] = err_nxt_s[i] | {usr_bresp == 2'b11, usr_bresp == 2'b10, 2'b00};
      end else begin
        err_nxt_s[i] = err_nxt_s[i];
      end
    end
  end

  // Channel state: command load, address/remaining advance, completion
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rdy_en_r <= 1'b0;
      busy_r   <= '0;
      irq_r    <= '0;
      gost_r   <= '0;
      for (int i = 0; i < NCH; i++) begin
        addr_r[i] <= 32'd0;
        rem_r[i]  <= 32'd0;
        ost_r[i]  <= '0;
        err_r[i]  <= 4'd0;
      end
    end else begin
      rdy_en_r <= 1'b1;
      gost_r   <= gost_r + OW'(hs_s) - OW'(rsp_ok_s && (gost_r != '0));
      for (int i = 0; i < NCH; i++) begin
        irq_r[i] <= irq_set_s[i] | (irq_r[i] & ~dma_irq_w1c[i]);
        err_r[i] <= err_nxt_s[i];
        ost_r[i] <= ost_r[i] + OW'(inc_s[i]) - OW'(dec_s[i]);
        if (acc_s[i] && !(sa_bad_s[i] || len_bad_s[i])) begin
          busy_r[i] <= 1'b1;
          addr_r[i] <= cfg_dma_sa[i*32 +: 32];
          rem_r[i]  <= cfg_dma_len[i*32 +: 32];
        end else if (inc_s[i]) begin
          addr_r[i] <= addr_r[i] + step_s;
          rem_r[i]  <= rem_r[i] - step_s;
        end else if (done_s[i]) begin
          busy_r[i] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_ami_burst_gen.sv
// Directed bench for ami_burst_gen (AXI_DW=128, BL=16, OD=4, NCH=4); logs burst handshakes
// and answers them from a small responder that can be throttled or made to send a stray ID.
module tb_ami_burst_gen;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [3:0]   cfg_dma_valid, cfg_dma_ready, dma_irq_w1c, dma_irq;
  logic [127:0] cfg_dma_sa, cfg_dma_len;
  logic [15:0]  dma_err;
  logic [7:0]   axid, axlen;
  logic [31:0]  axaddr;
  logic [2:0]   axsize;
  logic [1:0]   axburst;
  logic         axvalid, axready, usr_bready;
  logic [7:0]   usr_bid = 8'd0;
  logic [1:0]   usr_bresp = 2'b00;
  logic         usr_bvalid = 1'b0;

  ami_burst_gen dut (
    .clk(clk), .reset_n(reset_n),
    .cfg_dma_valid(cfg_dma_valid), .cfg_dma_ready(cfg_dma_ready),
    .cfg_dma_sa(cfg_dma_sa), .cfg_dma_len(cfg_dma_len),
    .dma_irq_w1c(dma_irq_w1c), .dma_irq(dma_irq), .dma_err(dma_err),
    .axid(axid), .axaddr(axaddr), .axlen(axlen), .axsize(axsize), .axburst(axburst),
    .axvalid(axvalid), .axready(axready),
    .usr_bid(usr_bid), .usr_bresp(usr_bresp), .usr_bvalid(usr_bvalid), .usr_bready(usr_bready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
  } hs_t;

  hs_t  hs_q[$];
  int   hs_base = 0;
  int   n_vec = 0;
  int   n_err = 0;
  logic resp_all = 1'b1;
  logic [1:0] resp_code = 2'b00;
  int   credit_req = 0, credit_used = 0;
  int   bogus_req = 0, bogus_used = 0;
  int   rsp_idx = 0;

  // Handshake log, sampled mid-cycle
  always @(negedge clk) begin
    if (reset_n && axvalid && axready) hs_q.push_back('{axid, axaddr, axlen});
  end

  // Write responder: one response per cycle, in handshake order
  always @(posedge clk) begin
    #1;
    usr_bvalid = 1'b0;
    if (bogus_req > bogus_used) begin
      usr_bvalid = 1'b1;
      usr_bid    = 8'd5;
      usr_bresp  = 2'b10;
      bogus_used++;
    end else if ((hs_q.size() > rsp_idx) && (resp_all || (credit_req > credit_used))) begin
      usr_bvalid = 1'b1;
      usr_bid    = hs_q[rsp_idx].id;
      usr_bresp  = resp_code;
      rsp_idx++;
      if (!resp_all) credit_used++;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic cmd(input int ch, input logic [31:0] sa, input logic [31:0] len);
    cfg_dma_valid[ch]      = 1'b1;
    cfg_dma_sa[ch*32 +: 32]  = sa;
    cfg_dma_len[ch*32 +: 32] = len;
    tick(1);
    cfg_dma_valid[ch] = 1'b0;
  endtask

  task automatic w1c(input logic [3:0] mask);
    dma_irq_w1c = mask;
    tick(1);
    dma_irq_w1c = 4'h0;
  endtask

  task automatic wait_irq(input int ch, input string tag);
    int c = 0;
    while (!dma_irq[ch] && (c < 400)) begin
      @(negedge clk);
      c++;
    end
    chk(tag, 64'(dma_irq[ch]), 64'd1);
    tick(1);
  endtask

  task automatic chk_hs(input int k, input logic [7:0] id, input logic [31:0] addr, input logic [7:0] len);
    if (hs_base + k < hs_q.size()) begin
      chk($sformatf("hs%0d_id", k),   64'(hs_q[hs_base+k].id),   64'(id));
      chk($sformatf("hs%0d_addr", k), 64'(hs_q[hs_base+k].addr), 64'(addr));
      chk($sformatf("hs%0d_len", k),  64'(hs_q[hs_base+k].len),  64'(len));
    end else begin
      chk($sformatf("hs%0d_present", k), 64'(hs_q.size()), 64'(hs_base + k + 1));
    end
  endtask

  function automatic int n_hs();
    return hs_q.size() - hs_base;
  endfunction

  initial begin
    reset_n = 1'b0;
    cfg_dma_valid = 4'h0; cfg_dma_sa = 128'd0; cfg_dma_len = 128'd0;
    dma_irq_w1c = 4'h0; axready = 1'b1;
    tick(2);
    chk("rst_ready", 64'(cfg_dma_ready), 64'h0);
    chk("rst_axvalid", 64'(axvalid), 64'h0);
    chk("rst_fields", {axid, axaddr, axlen}, 64'h0);
    chk("rst_irq_err", {dma_irq, dma_err}, 64'h0);
    chk("const_size_burst", {usr_bready, axsize, axburst}, {58'd0, 1'b1, 3'd4, 2'b01});
    reset_n = 1'b1;
    tick(1);
    chk("rel_ready", 64'(cfg_dma_ready), 64'hF);

    // Four full bursts on ch0
    cmd(0, 32'h1000, 32'h400);
    wait_irq(0, "r18_irq");
    chk("r18_cnt", 64'(n_hs()), 64'd4);
    for (int k = 0; k < 4; k++) chk_hs(k, 8'd0, 32'h1000 + 32'(k) * 32'h100, 8'd15);
    chk("r18_err", 64'(dma_err), 64'h0);
    w1c(4'h1);
    chk("r18_clr", {cfg_dma_ready, dma_irq}, {56'd0, 4'hF, 4'h0});
    hs_base = hs_q.size();

    // Page-crossing command
    cmd(0, 32'h0FC0, 32'h100);
    wait_irq(0, "r19_irq");
`ifdef AMI_BG_4K_SPLIT_EN
    chk("r19_cnt", 64'(n_hs()), 64'd2);
    chk_hs(0, 8'd0, 32'h0FC0, 8'd3);
    chk_hs(1, 8'd0, 32'h1000, 8'd11);
`else
    chk("r19_cnt", 64'(n_hs()), 64'd1);
    chk_hs(0, 8'd0, 32'h0FC0, 8'd15);
`endif
    w1c(4'h1);
    hs_base = hs_q.size();

    // ch1 and ch2 accepted together interleave 1,2,1,2
    cfg_dma_valid = 4'b0110;
    cfg_dma_sa = 128'd0;
    cfg_dma_len[32 +: 32] = 32'h200;
    cfg_dma_len[64 +: 32] = 32'h200;
    tick(1);
    cfg_dma_valid = 4'h0;
    wait_irq(2, "r20_irq2");
    chk("r20_irq", 64'(dma_irq), 64'h6);
    chk("r20_cnt", 64'(n_hs()), 64'd4);
    chk_hs(0, 8'd1, 32'h000, 8'd15);
    chk_hs(1, 8'd2, 32'h000, 8'd15);
    chk_hs(2, 8'd1, 32'h100, 8'd15);
    chk_hs(3, 8'd2, 32'h100, 8'd15);
    w1c(4'h6);
    hs_base = hs_q.size();

    // Outstanding limit, stalled axready and a stray response ID
    resp_all = 1'b0;
    axready  = 1'b0;
    cmd(0, 32'h0, 32'h1000);
    tick(6);
    chk("r21_stall", {axvalid, axaddr, axlen}, {23'd0, 1'b1, 32'h0, 8'd15});
    tick(3);
    chk("r21_hold", {axvalid, axaddr, axlen}, {23'd0, 1'b1, 32'h0, 8'd15});
    axready = 1'b1;
    tick(30);
    chk("r21_cap", 64'(n_hs()), 64'd4);
    chk("r21_idle", 64'(axvalid), 64'd0);
    bogus_req++;
    tick(20);
    chk("r21_stray_id", 64'(n_hs()), 64'd4);
    credit_req++;
    tick(20);
    chk("r21_one_more", 64'(n_hs()), 64'd5);
    resp_all = 1'b1;
    wait_irq(0, "r21_irq");
    chk("r21_total", 64'(n_hs()), 64'd16);
    chk_hs(15, 8'd0, 32'hF00, 8'd15);
    chk("r21_err", 64'(dma_err), 64'h0);
    w1c(4'h1);
    hs_base = hs_q.size();

    // Rejected commands: misaligned sa, bad len, both
    cmd(3, 32'h1004, 32'h100);
    chk("r22_sa", {dma_irq[3], dma_err[15:12], cfg_dma_ready[3]}, {58'd0, 1'b1, 4'b0001, 1'b0});
    cmd(2, 32'h0, 32'h108);
    chk("r22_len", {dma_irq[2], dma_err[11:8]}, {59'd0, 1'b1, 4'b0010});
    cmd(1, 32'h8, 32'h0);
    chk("r22_both", {dma_irq[1], dma_err[7:4]}, {59'd0, 1'b1, 4'b0011});
    tick(10);
    chk("r22_nobursts", 64'(n_hs()), 64'd0);
    w1c(4'hE);
    chk("r22_clr", {cfg_dma_ready, dma_irq, dma_err}, {40'd0, 4'hF, 4'h0, 16'h0});

    // SLVERR response is reported at done
    resp_code = 2'b10;
    cmd(0, 32'h0, 32'h100);
    wait_irq(0, "r22_slv_irq");
    chk("r22_slv_err", 64'(dma_err), 64'h4);
    w1c(4'h1);
    chk("r22_slv_clr", {cfg_dma_ready, dma_irq, dma_err}, {40'd0, 4'hF, 4'h0, 16'h0});
    resp_code = 2'b00;
    hs_base = hs_q.size();

    // One-cycle reset after two of four bursts
    cmd(0, 32'h1000, 32'h400);
    for (int c = 0; (c < 200) && (n_hs() < 2); c++) begin
      @(negedge clk);
      #1;
    end
    chk("r23_two", 64'(n_hs()), 64'd2);
    tick(1);
    reset_n = 1'b0;
    tick(1);
    chk("r23_rst", {cfg_dma_ready, axvalid, dma_irq, dma_err}, 64'h0);
    chk("r23_fields", {axid, axaddr, axlen}, 64'h0);
    reset_n = 1'b1;
    tick(1);
    chk("r23_ready", 64'(cfg_dma_ready), 64'hF);
    tick(20);
    chk("r23_quiet", {n_hs(), 3'd0, axvalid, dma_irq}, 64'({32'd2, 3'd0, 1'b0, 4'h0}));
    hs_base = hs_q.size();
    cmd(0, 32'h0, 32'h100);
    wait_irq(0, "r23_new_irq");
    chk("r23_new_cnt", 64'(n_hs()), 64'd1);
    w1c(4'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
